prbs8_checker: RTL and testbench
================================

Name: prbs8_checker

Overview:
Downstream consumer of the 8-bit Fibonacci LFSR pattern generator (polynomial x^8+x^6+x^5+x^4+1, left shift, feedback into bit 0). It receives the generator's byte stream, possibly after a link or datapath under test, and self-synchronises to it. Once locked, it free-runs its own expected-sequence register and counts byte errors. It gives BIST and link tests a lock flag, a per-error pulse and a saturating error count.

Parameters:
LOCK_CNT, 4, consecutive correct successor bytes needed in SEARCH to declare lock (1..15).
UNLOCK_CNT, 3, consecutive mismatching bytes in LOCKED that force a return to SEARCH (1..15).
ERR_W, 16, width of the error counter.

Ports:
MCLK  in  1  system clock; all logic on the rising edge.
MRST  in  1  reset, asynchronous, active-high.
DATA_IN  in  8  received pattern byte.
DATA_VLD  in  1  DATA_IN is valid this cycle; no backpressure.
CLR_CNT  in  1  synchronous clear of ERR_CNT.
LOCKED  out  1  checker is locked to the sequence.
ERR_PULSE  out  1  one-cycle pulse per mismatching byte while locked.
ERR_CNT  out  ERR_W  saturating count of mismatching bytes.

Behaviour:
- Interface: one clock, MCLK. Reset MRST is asynchronous and active-high.
- Successor function: NXT(x) = {x[6:0], x[7]^x[5]^x[4]^x[3]}. It matches the generator exactly.
- Reset values: LOCKED=0, ERR_PULSE=0, ERR_CNT=0, state=SEARCH. Internal prev/exp=0x00, have_prev=0, match_cnt=0, bad_cnt=0.
- Cycles with DATA_VLD=0 change nothing except CLR_CNT handling and ERR_PULSE returning to 0.
- SEARCH state, on each valid byte:
  - prev<=DATA_IN and have_prev<=1.
  - If have_prev && DATA_IN==NXT(prev) && DATA_IN!=0x00, then match_cnt+1. Otherwise match_cnt<=0.
  - The all-zero byte is the LFSR lock-up state and never counts as a match.
  - When the increment makes match_cnt reach LOCK_CNT: state<=LOCKED, exp<=NXT(DATA_IN), bad_cnt<=0, match_cnt<=0. LOCKED is high from the next cycle.
- LOCKED state, on each valid byte:
  - exp<=NXT(exp) on every valid byte. The checker free-runs and is never reseeded from the input.
  - DATA_IN!=exp: ERR_PULSE=1 in the next cycle, ERR_CNT+1 (saturates at all-ones, no wrap), bad_cnt+1.
  - DATA_IN==exp: bad_cnt<=0.
  - When bad_cnt reaches UNLOCK_CNT: state<=SEARCH, have_prev<=0, match_cnt<=0, LOCKED low from the next cycle. ERR_CNT is retained.
- ERR_PULSE is registered with one-cycle latency and is never high in SEARCH-only operation.
- CLR_CNT: ERR_CNT<=0 on the next edge.
  - If CLR_CNT and an error increment occur in the same cycle, clear wins: ERR_CNT=0. ERR_PULSE still fires.
  - CLR_CNT does not affect lock state.
- MRST asserted mid-operation returns everything to reset values immediately, without waiting for a clock edge.
- Lock latency from reset with a clean stream: LOCK_CNT+1 valid bytes, plus one cycle until LOCKED is visible.

Test Plan:
- Lock: after reset, feed 0x01,0x02,0x04,0x08,0x11 on consecutive cycles with DATA_VLD=1 -> LOCKED=1 in the cycle after 0x11. Continue with 0x23,0x47 -> no ERR_PULSE, ERR_CNT=0.
- Single error: when locked and 0x47 is expected, send 0x46, then the correct continuation -> one ERR_PULSE, ERR_CNT=1, LOCKED stays 1, and the following bytes compare clean.
- Unlock: when locked, send 3 consecutive wrong bytes -> ERR_CNT=3, LOCKED=0 one cycle after the third. Then a fresh run of 5 correct bytes relocks, and ERR_CNT stays 3.
- Gaps and zero: in SEARCH, interleave DATA_VLD=0 cycles between 0x01,0x02,0x04 -> match progress is preserved. Sending 0x00,0x00 repeatedly -> never locks.
- Saturation and clear: with ERR_W=4, force 20 errors using UNLOCK_CNT=15 and correct bytes in between -> ERR_CNT holds 0xF. Assert CLR_CNT together with an error -> ERR_CNT=0 and ERR_PULSE=1.
- Async reset: assert MRST between clock edges while locked -> LOCKED and ERR_CNT go to 0 with no clock edge. After release, a relock needs the full LOCK_CNT+1 bytes.

Source files
------------

// File: rtl/prbs8_checker.sv
// prbs8_checker: self-synchronising checker for the 8-bit PRBS stream
// (x^8+x^6+x^5+x^4+1, left shift, feedback into bit 0). It acquires lock
// from the incoming bytes, then free-runs its own expected sequence and
// counts mismatching bytes in a saturating counter.
//
// state  | meaning
// SEARCH | tracking successive input bytes, counting correct successors
// LOCK   | free-running expected sequence, counting byte errors
module prbs8_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             MCLK,
  input  logic             MRST,
  input  logic [7:0]       DATA_IN,
  input  logic             DATA_VLD,
  input  logic             CLR_CNT,
  output logic             LOCKED,
  output logic             ERR_PULSE,
  output logic [ERR_W-1:0] ERR_CNT
);

  typedef enum logic {ST_SEARCH = 1'b0, ST_LOCK = 1'b1} state_t;

  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       prev_q, prev_d;
  logic [7:0]       exp_q, exp_d;
  logic             have_prev_q, have_prev_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       bad_cnt_q, bad_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             err_inc;
  logic [3:0]       match_inc;
  logic [3:0]       bad_inc;

  assign match_inc = match_cnt_q + 4'd1;
  assign bad_inc   = bad_cnt_q + 4'd1;

  // Register all checker state; reset clears everything asynchronously.
  always_ff @(posedge MCLK or posedge MRST) begin
    if (MRST) begin
      state_q     <= ST_SEARCH;
      prev_q      <= 8'h00;
      exp_q       <= 8'h00;
      have_prev_q <= 1'b0;
      match_cnt_q <= 4'd0;
      bad_cnt_q   <= 4'd0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      exp_q       <= exp_d;
      have_prev_q <= have_prev_d;
      match_cnt_q <= match_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Next-state: acquisition in SEARCH, free-running compare in LOCK.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    exp_d       = exp_q;
    have_prev_d = have_prev_q;
    match_cnt_d = match_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;

    if (DATA_VLD) begin
      case (state_q)
        ST_SEARCH: begin
          prev_d      = DATA_IN;
          have_prev_d = 1'b1;
          // The all-zero byte is the LFSR lock-up state and never matches.
          if (have_prev_q && (DATA_IN == nxt(prev_q)) && (DATA_IN != 8'h00)) begin
            if (match_inc == LOCK_C) begin
              state_d     = ST_LOCK;
              exp_d       = nxt(DATA_IN);
              bad_cnt_d   = 4'd0;
              match_cnt_d = 4'd0;
            end else begin
              match_cnt_d = match_inc;
            end
          end else begin
            match_cnt_d = 4'd0;
          end
        end
        ST_LOCK: begin
          // Never reseeded from the input once locked.
          exp_d = nxt(exp_q);
          if (DATA_IN != exp_q) begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            bad_cnt_d   = bad_inc;
            if (bad_inc == UNLOCK_C) begin
              state_d     = ST_SEARCH;
              have_prev_d = 1'b0;
              match_cnt_d = 4'd0;
            end
          end else begin
            bad_cnt_d = 4'd0;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    // Clear takes priority over a simultaneous error increment.
    err_cnt_d = err_cnt_q;
    if (CLR_CNT) begin
      err_cnt_d = '0;
    end else if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_ONE;
    end
  end

  assign LOCKED    = (state_q == ST_LOCK);
  assign ERR_PULSE = err_pulse_q;
  assign ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// Directed bench for prbs8_checker. Two instances: default parameters, and a
// narrow-counter variant (ERR_W=4, UNLOCK_CNT=15) for saturation and clear.
module tb_prbs8_checker;

  logic       clk;
  logic       rst;
  logic [7:0] a_din, b_din;
  logic       a_vld, b_vld, a_clr, b_clr;
  logic       a_locked, b_locked, a_pulse, b_pulse;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  prbs8_checker u_a (
    .MCLK(clk), .MRST(rst), .DATA_IN(a_din), .DATA_VLD(a_vld), .CLR_CNT(a_clr),
    .LOCKED(a_locked), .ERR_PULSE(a_pulse), .ERR_CNT(a_cnt)
  );

  prbs8_checker #(.LOCK_CNT(4), .UNLOCK_CNT(15), .ERR_W(4)) u_b (
    .MCLK(clk), .MRST(rst), .DATA_IN(b_din), .DATA_VLD(b_vld), .CLR_CNT(b_clr),
    .LOCKED(b_locked), .ERR_PULSE(b_pulse), .ERR_CNT(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          inst;
    logic        locked;
    logic        pulse;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  // Drive one cycle of stimulus on the selected instance and queue what the
  // outputs must show after the following rising edge.
  task automatic drv(input bit inst, input logic v, input logic [7:0] d, input logic c,
                     input string tag, input logic el, input logic ep, input logic [15:0] ec);
    exp_t e;
    @(negedge clk);
    a_vld = 1'b0; a_clr = 1'b0; b_vld = 1'b0; b_clr = 1'b0;
    if (!inst) begin a_vld = v; a_din = d; a_clr = c; end
    else       begin b_vld = v; b_din = d; b_clr = c; end
    e.tag = tag; e.inst = inst; e.locked = el; e.pulse = ep; e.cnt = ec;
    q.push_back(e);
  endtask

  // Scoreboard: compare queued expectations just after each rising edge.
  exp_t        ce;
  logic        ol, op;
  logic [15:0] oc;
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      ce = q.pop_front();
      if (!ce.inst) begin ol = a_locked; op = a_pulse; oc = a_cnt; end
      else          begin ol = b_locked; op = b_pulse; oc = {12'h000, b_cnt}; end
      checks++;
      assert (ol === ce.locked) else begin
        errors++; $error("FAIL %s locked got=%0b exp=%0b", ce.tag, ol, ce.locked);
      end
      checks++;
      assert (op === ce.pulse) else begin
        errors++; $error("FAIL %s err_pulse got=%0b exp=%0b", ce.tag, op, ce.pulse);
      end
      checks++;
      assert (oc === ce.cnt) else begin
        errors++; $error("FAIL %s err_cnt got=%0d exp=%0d", ce.tag, oc, ce.cnt);
      end
    end
  end

  task automatic chk_async(input string tag);
    checks++;
    assert (a_locked === 1'b0) else begin
      errors++; $error("FAIL %s locked got=%0b exp=0", tag, a_locked);
    end
    checks++;
    assert (a_cnt === 16'd0) else begin
      errors++; $error("FAIL %s err_cnt got=%0d exp=0", tag, a_cnt);
    end
  endtask

  logic [7:0] s;

  initial begin
    rst = 1'b1;
    a_din = 8'h00; b_din = 8'h00;
    a_vld = 1'b0; b_vld = 1'b0; a_clr = 1'b0; b_clr = 1'b0;
    #2;
    chk_async("reset_a");
    checks++;
    assert (a_pulse === 1'b0 && b_locked === 1'b0 && b_pulse === 1'b0 && b_cnt === 4'd0) else begin
      errors++; $error("FAIL reset_misc got=%0b%0b%0b%0d exp=0000", a_pulse, b_locked, b_pulse, b_cnt);
    end
    @(negedge clk); rst = 1'b0;

    // Lock on a clean stream, then a single error and clean continuation.
    drv(0, 1, 8'h01, 0, "lock_01", 0, 0, 0);
    drv(0, 1, 8'h02, 0, "lock_02", 0, 0, 0);
    drv(0, 1, 8'h04, 0, "lock_04", 0, 0, 0);
    drv(0, 1, 8'h08, 0, "lock_08", 0, 0, 0);
    drv(0, 1, 8'h11, 0, "lock_11", 1, 0, 0);
    drv(0, 1, 8'h23, 0, "clean_23", 1, 0, 0);
    drv(0, 1, 8'h46, 0, "err_46", 1, 1, 1);
    s = nxt(8'h47);
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, s, 0, $sformatf("after_err_%0d", i), 1, 0, 1);
      s = nxt(s);
    end
    drv(0, 0, 8'h00, 1, "clr_idle", 1, 0, 0);

    // Three consecutive errors unlock; counter retained through relock.
    drv(0, 1, s ^ 8'hFF, 0, "bad1", 1, 1, 1); s = nxt(s);
    drv(0, 1, s ^ 8'hFF, 0, "bad2", 1, 1, 2); s = nxt(s);
    drv(0, 1, s ^ 8'hFF, 0, "bad3", 0, 1, 3); s = nxt(s);
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, s, 0, $sformatf("relock_%0d", i), 0, 0, 3);
      s = nxt(s);
    end
    drv(0, 1, s, 0, "relock_4", 1, 0, 3); s = nxt(s);
    drv(0, 1, s, 0, "relock_clean", 1, 0, 3); s = nxt(s);

    // Asynchronous reset between edges while locked.
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk_async("async_rst1");
    @(negedge clk); rst = 1'b0;

    // Gaps in SEARCH preserve progress; full LOCK_CNT+1 bytes needed.
    drv(0, 1, 8'h01, 0, "gap_01", 0, 0, 0);
    drv(0, 0, 8'h00, 0, "gap_idle1", 0, 0, 0);
    drv(0, 1, 8'h02, 0, "gap_02", 0, 0, 0);
    drv(0, 0, 8'h55, 0, "gap_idle2", 0, 0, 0);
    drv(0, 0, 8'hAA, 0, "gap_idle3", 0, 0, 0);
    drv(0, 1, 8'h04, 0, "gap_04", 0, 0, 0);
    drv(0, 1, 8'h08, 0, "gap_08", 0, 0, 0);
    drv(0, 1, 8'h11, 0, "gap_11", 1, 0, 0);

    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_async("async_rst2");
    @(negedge clk); rst = 1'b0;

    // Zero bytes never lock; a broken chain restarts the match count.
    for (int i = 0; i < 6; i++) drv(0, 1, 8'h00, 0, $sformatf("zero_%0d", i), 0, 0, 0);
    s = 8'h33;
    drv(0, 1, s, 0, "chain_seed", 0, 0, 0); s = nxt(s);
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, s, 0, $sformatf("chain_%0d", i), 0, 0, 0);
      s = nxt(s);
    end
    drv(0, 1, s, 0, "chain_lock", 1, 0, 0);

    // Narrow counter: saturation at 0xF, then clear beats a same-cycle error.
    drv(1, 1, 8'h01, 0, "b_lock_01", 0, 0, 0);
    drv(1, 1, 8'h02, 0, "b_lock_02", 0, 0, 0);
    drv(1, 1, 8'h04, 0, "b_lock_04", 0, 0, 0);
    drv(1, 1, 8'h08, 0, "b_lock_08", 0, 0, 0);
    drv(1, 1, 8'h11, 0, "b_lock_11", 1, 0, 0);
    s = 8'h23;
    for (int i = 0; i < 20; i++) begin
      drv(1, 1, s ^ 8'hFF, 0, $sformatf("sat_bad_%0d", i), 1, 1, (i + 1 > 15) ? 16'd15 : 16'(i + 1));
      s = nxt(s);
      drv(1, 1, s, 0, $sformatf("sat_good_%0d", i), 1, 0, (i + 1 > 15) ? 16'd15 : 16'(i + 1));
      s = nxt(s);
    end
    drv(1, 1, s ^ 8'hFF, 1, "clr_with_err", 1, 1, 0); s = nxt(s);
    drv(1, 1, s, 0, "after_clr", 1, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    assert (q.size() == 0) else begin
      errors++; $error("FAIL queue_drain got=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
